// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and default sizing for the PE array tile-pass sequencer.
package pe_ctrl_pkg;

  localparam int NUM_DEF     = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int LEN_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_COMPUTE,
    S_WAIT,
    S_DRAIN
  } pe_ctrl_state_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Command, buffer-port and PE-array control signals of the tile-pass sequencer.
interface pe_array_ctrl_if
  import pe_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              start_valid;
  logic              start_ready;
  logic [ADDR_W-1:0] cfg_w_base;
  logic [ADDR_W-1:0] cfg_i_base;
  logic [ADDR_W-1:0] cfg_o_base;
  logic [LEN_W-1:0]  cfg_len;
  logic              wbuf_rd_en;
  logic [ADDR_W-1:0] wbuf_rd_addr;
  logic              ibuf_rd_en;
  logic [ADDR_W-1:0] ibuf_rd_addr;
  logic              p_en;
  logic              c_en;
  logic              compute_finished;
  logic              obuf_wr_en;
  logic [ADDR_W-1:0] obuf_wr_addr;
  logic              busy;
  logic              done;
  logic              err;

  // Host / PE-array side.
  modport master (
    output start_valid, cfg_w_base, cfg_i_base, cfg_o_base, cfg_len, compute_finished,
    input  start_ready, wbuf_rd_en, wbuf_rd_addr, ibuf_rd_en, ibuf_rd_addr,
           p_en, c_en, obuf_wr_en, obuf_wr_addr, busy, done, err
  );

  // Sequencer side.
  modport slave (
    input  start_valid, cfg_w_base, cfg_i_base, cfg_o_base, cfg_len, compute_finished,
    output start_ready, wbuf_rd_en, wbuf_rd_addr, ibuf_rd_en, ibuf_rd_addr,
           p_en, c_en, obuf_wr_en, obuf_wr_addr, busy, done, err
  );

endinterface

// File: rtl/pe_array_ctrl.sv
// Tile-pass sequencer: preload weights, stream inputs, wait for the array, drain results.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int NUM     = NUM_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LEN_W   = LEN_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          reset,
  pe_array_ctrl_if.slave bus
);

  localparam int CNT_W = maxOf($clog2(NUM), LEN_W);
  localparam int TO_W  = maxOf($clog2(TIMEOUT + 1), 1);

  pe_ctrl_state_t    r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [TO_W-1:0]   r_tcnt;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_wbufRdAddr;
  logic [ADDR_W-1:0] r_ibufRdAddr;
  logic [ADDR_W-1:0] r_obufWrAddr;
  logic              r_wbufRdEn;
  logic              r_ibufRdEn;
  logic              r_pEn;
  logic              r_cEn;
  logic              r_done;
  logic              r_err;

  logic [CNT_W:0]    w_cntNext;
  logic              w_rowLast;
  logic              w_computeLast;
  logic              w_timeoutLast;
  logic              w_cfHit;

  assign w_cntNext     = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_rowLast     = (w_cntNext == (CNT_W + 1)'(NUM));
  assign w_computeLast = (w_cntNext == (CNT_W + 1)'(r_len));
  assign w_timeoutLast = (r_tcnt == TO_W'(TIMEOUT - 1));
  assign w_cfHit       = (r_state == S_WAIT) && bus.compute_finished;

  // Row 0 is written in the same cycle the array reports completion, so the
  // write strobe and the falling edge of c_en are combinational on that input.
  assign bus.start_ready  = (r_state == S_IDLE);
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.wbuf_rd_en   = r_wbufRdEn;
  assign bus.wbuf_rd_addr = r_wbufRdAddr;
  assign bus.ibuf_rd_en   = r_ibufRdEn;
  assign bus.ibuf_rd_addr = r_ibufRdAddr;
  assign bus.p_en         = r_pEn;
  assign bus.c_en         = r_cEn && !w_cfHit;
  assign bus.obuf_wr_en   = w_cfHit || (r_state == S_DRAIN);
  assign bus.obuf_wr_addr = r_obufWrAddr;
  assign bus.done         = r_done;
  assign bus.err          = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tcnt       <= '0;
      r_len        <= '0;
      r_wbufRdAddr <= '0;
      r_ibufRdAddr <= '0;
      r_obufWrAddr <= '0;
      r_wbufRdEn   <= 1'b0;
      r_ibufRdEn   <= 1'b0;
      r_pEn        <= 1'b0;
      r_cEn        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_pEn  <= r_wbufRdEn;
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid) begin
            r_wbufRdAddr <= bus.cfg_w_base;
            r_ibufRdAddr <= bus.cfg_i_base;
            r_obufWrAddr <= bus.cfg_o_base;
            r_len        <= bus.cfg_len;
            r_cnt        <= '0;
            // An empty stream is acknowledged with an error and never leaves IDLE.
            if (bus.cfg_len == '0) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state    <= S_PRELOAD;
              r_wbufRdEn <= 1'b1;
            end
          end
        end
        S_PRELOAD: begin
          if (w_rowLast) begin
            r_state    <= S_COMPUTE;
            r_wbufRdEn <= 1'b0;
            r_ibufRdEn <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_cnt        <= w_cntNext[CNT_W-1:0];
            r_wbufRdAddr <= r_wbufRdAddr + ADDR_W'(1);
          end
        end
        S_COMPUTE: begin
          r_cEn <= 1'b1;
          if (w_computeLast) begin
            r_state    <= S_WAIT;
            r_ibufRdEn <= 1'b0;
            r_tcnt     <= '0;
          end else begin
            r_cnt        <= w_cntNext[CNT_W-1:0];
            r_ibufRdAddr <= r_ibufRdAddr + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          if (bus.compute_finished) begin
            r_cEn        <= 1'b0;
            r_obufWrAddr <= r_obufWrAddr + ADDR_W'(1);
            if (NUM == 1) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              r_cnt   <= CNT_W'(1);
            end
          end else if (w_timeoutLast) begin
            r_state <= S_IDLE;
            r_cEn   <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        S_DRAIN: begin
          r_obufWrAddr <= r_obufWrAddr + ADDR_W'(1);
          if (w_rowLast) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= w_cntNext[CNT_W-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: directed passes push expected events, a negedge monitor pops them.
module tb_pe_array_ctrl;
  import pe_ctrl_pkg::*;

  localparam int NUM     = NUM_DEF;
  localparam int TIMEOUT = 8;
  localparam int EV_W = 0, EV_I = 1, EV_P = 2, EV_C = 3, EV_O = 4, EV_D = 5;

  typedef struct packed {
    int         cyc;
    logic [7:0] addr;
    logic       err;
  } ev_t;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] i;
    logic [7:0] o;
    logic [7:0] len;
    int         cfRel;
    int         spurRel;
    int         resetRel;
    int         expDoneRel;
    logic       expErr;
    logic       hold;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  ev_t  evQ[6][$];
  vec_t vecs[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_array_ctrl_if #(.ADDR_W(8), .LEN_W(8)) bus();

  pe_array_ctrl #(
    .NUM(NUM), .ADDR_W(8), .LEN_W(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic pushEv(input int s, input int c, input logic [7:0] a, input logic e);
    ev_t x;
    x.cyc = c;
    x.addr = a;
    x.err = e;
    evQ[s].push_back(x);
  endtask

  task automatic popCheck(input int s, input string name, input logic [7:0] a, input logic e,
                          input bit useAddr, input bit useErr);
    ev_t x;
    if (evQ[s].size() == 0) begin
      checkOutput({name, " unexpected"}, 1, 0);
    end else begin
      x = evQ[s].pop_front();
      checkOutput({name, " cycle"}, cyc, x.cyc);
      if (useAddr) checkOutput({name, " addr"}, {24'd0, a}, {24'd0, x.addr});
      if (useErr) checkOutput({name, " err"}, {31'd0, e}, {31'd0, x.err});
    end
  endtask

  // Monitor: every active output strobe must match the next expected event of its stream.
  always @(negedge clk) begin
    if (bus.wbuf_rd_en === 1'b1) popCheck(EV_W, "wbuf_rd", bus.wbuf_rd_addr, 1'b0, 1, 0);
    if (bus.ibuf_rd_en === 1'b1) popCheck(EV_I, "ibuf_rd", bus.ibuf_rd_addr, 1'b0, 1, 0);
    if (bus.p_en === 1'b1) popCheck(EV_P, "p_en", 8'd0, 1'b0, 0, 0);
    if (bus.c_en === 1'b1) popCheck(EV_C, "c_en", 8'd0, 1'b0, 0, 0);
    if (bus.obuf_wr_en === 1'b1) popCheck(EV_O, "obuf_wr", bus.obuf_wr_addr, 1'b0, 1, 0);
    if (bus.done === 1'b1) popCheck(EV_D, "done", 8'd0, bus.err, 0, 1);
    if (bus.err === 1'b1 && bus.done !== 1'b1) checkOutput("err without done", 1, 0);
  end

  // Runs one pass starting in the current cycle (rel 0 = handshake cycle) and
  // returns in its done cycle, or in the cycle after an injected reset.
  task automatic applyStimulus(input vec_t v);
    int base;
    int lim;
    int cEnd;
    int endRel;
    base = cyc;
    bus.cfg_w_base = v.w;
    bus.cfg_i_base = v.i;
    bus.cfg_o_base = v.o;
    bus.cfg_len = v.len;
    bus.start_valid = 1'b1;
    lim = (v.resetRel >= 0) ? v.resetRel : 32'h7fff_ffff;
    if (v.len != 0) begin
      for (int k = 0; k < NUM; k++) begin
        if (1 + k <= lim) pushEv(EV_W, base + 1 + k, 8'(v.w + k), 1'b0);
        if (2 + k <= lim) pushEv(EV_P, base + 2 + k, 8'd0, 1'b0);
      end
      for (int j = 0; j < int'(v.len); j++)
        if (NUM + 1 + j <= lim) pushEv(EV_I, base + NUM + 1 + j, 8'(v.i + j), 1'b0);
      if (v.resetRel >= 0) cEnd = v.resetRel;
      else if (v.cfRel >= 0) cEnd = v.cfRel - 1;
      else cEnd = v.expDoneRel - 1;
      for (int r = NUM + 2; r <= cEnd; r++) pushEv(EV_C, base + r, 8'd0, 1'b0);
      if (v.cfRel >= 0)
        for (int r = 0; r < NUM; r++)
          if (v.cfRel + r <= lim) pushEv(EV_O, base + v.cfRel + r, 8'(v.o + r), 1'b0);
    end
    if (v.resetRel < 0) pushEv(EV_D, base + v.expDoneRel, 8'd0, v.expErr);

    endRel = (v.resetRel >= 0) ? v.resetRel + 1 : v.expDoneRel;
    for (int rel = 1; rel <= endRel; rel++) begin
      @(posedge clk);
      #1;
      bus.compute_finished = (rel == v.cfRel) || (rel == v.spurRel);
      reset = (rel == v.resetRel);
      if (rel == 1) begin
        if (!v.hold) bus.start_valid = 1'b0;
        checkOutput("busy after handshake", {31'd0, bus.busy}, {31'd0, v.len != 0});
        checkOutput("start_ready after handshake", {31'd0, bus.start_ready}, {31'd0, v.len == 0});
      end
    end

    if (v.resetRel >= 0) begin
      checkOutput("post-reset wbuf_rd_en", {31'd0, bus.wbuf_rd_en}, 0);
      checkOutput("post-reset ibuf_rd_en", {31'd0, bus.ibuf_rd_en}, 0);
      checkOutput("post-reset p_en", {31'd0, bus.p_en}, 0);
      checkOutput("post-reset c_en", {31'd0, bus.c_en}, 0);
      checkOutput("post-reset obuf_wr_en", {31'd0, bus.obuf_wr_en}, 0);
      checkOutput("post-reset done", {31'd0, bus.done}, 0);
      checkOutput("post-reset err", {31'd0, bus.err}, 0);
      checkOutput("post-reset start_ready", {31'd0, bus.start_ready}, 1);
    end else begin
      checkOutput("done-cycle start_ready", {31'd0, bus.start_ready}, 1);
      checkOutput("done-cycle busy", {31'd0, bus.busy}, 0);
      checkOutput("done-cycle c_en", {31'd0, bus.c_en}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.start_valid = 1'b0;
    bus.cfg_w_base = '0;
    bus.cfg_i_base = '0;
    bus.cfg_o_base = '0;
    bus.cfg_len = '0;
    bus.compute_finished = 1'b0;

    //          w      i      o      len   cf  spur rst done err hold
    vecs[0] = '{8'h10, 8'h20, 8'h40, 8'd6, 14, -1, -1, 18, 1'b0, 1'b0}; // nominal
    vecs[1] = '{8'h50, 8'h60, 8'h70, 8'd0, -1, -1, -1,  1, 1'b1, 1'b0}; // zero length
    vecs[2] = '{8'h00, 8'h00, 8'h80, 8'd2, -1, -1, -1, 15, 1'b1, 1'b0}; // timeout
    vecs[3] = '{8'h10, 8'h20, 8'h40, 8'd6, -1, -1,  7,  0, 1'b0, 1'b0}; // reset mid-COMPUTE
    vecs[4] = '{8'h30, 8'h38, 8'h48, 8'd2,  8, -1, -1, 12, 1'b0, 1'b0}; // pass after reset
    vecs[5] = '{8'h01, 8'h02, 8'h03, 8'd1,  6, -1, -1, 10, 1'b0, 1'b1}; // start_valid held
    vecs[6] = '{8'hFC, 8'hFE, 8'hFE, 8'd4,  9, -1, -1, 13, 1'b0, 1'b0}; // address wrap
    vecs[7] = '{8'h20, 8'h30, 8'h40, 8'd3, 10,  2, -1, 14, 1'b0, 1'b0}; // spurious cf

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset start_ready", {31'd0, bus.start_ready}, 1);
    checkOutput("reset busy", {31'd0, bus.busy}, 0);
    checkOutput("reset wbuf_rd_en", {31'd0, bus.wbuf_rd_en}, 0);
    checkOutput("reset ibuf_rd_en", {31'd0, bus.ibuf_rd_en}, 0);
    checkOutput("reset p_en", {31'd0, bus.p_en}, 0);
    checkOutput("reset c_en", {31'd0, bus.c_en}, 0);
    checkOutput("reset obuf_wr_en", {31'd0, bus.obuf_wr_en}, 0);
    checkOutput("reset done", {31'd0, bus.done}, 0);
    checkOutput("reset err", {31'd0, bus.err}, 0);

    for (int n = 0; n < 8; n++) applyStimulus(vecs[n]);

    repeat (6) @(posedge clk);
    #1;
    checkOutput("leftover wbuf_rd events", evQ[EV_W].size(), 0);
    checkOutput("leftover ibuf_rd events", evQ[EV_I].size(), 0);
    checkOutput("leftover p_en events", evQ[EV_P].size(), 0);
    checkOutput("leftover c_en events", evQ[EV_C].size(), 0);
    checkOutput("leftover obuf_wr events", evQ[EV_O].size(), 0);
    checkOutput("leftover done events", evQ[EV_D].size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
